// File: rtl/axis_perf_mon_mc.sv
// Passive multi-channel AXI-Stream monitor: counts cycles, beats, bytes, packets and stalls per channel.
// Counter outputs are registered and lag the observed handshake by one cycle; it only taps the streams and never applies backpressure.
module axis_perf_mon_mc #(
    parameter int NUM_CH     = 2,
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_CH-1:0]              mon_tvalid,
    input  logic [NUM_CH-1:0]              mon_tready,
    input  logic [NUM_CH-1:0]              mon_tlast,
    input  logic [NUM_CH*KEEP_WIDTH-1:0]   mon_tkeep,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           start_on_first,
    input  logic [CNT_WIDTH-1:0]           window_cycles,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_WIDTH-1:0]           cycle_count,
    output logic [NUM_CH*CNT_WIDTH-1:0]    beat_count,
    output logic [NUM_CH*CNT_WIDTH-1:0]    byte_count,
    output logic [NUM_CH*CNT_WIDTH-1:0]    pkt_count,
    output logic [NUM_CH*CNT_WIDTH-1:0]    stall_count,
    output logic [NUM_CH-1:0]              cnt_full
);

    localparam int PC_W = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] win_r;
    logic [CNT_WIDTH-1:0] cycle_r;
    logic [CNT_WIDTH-1:0] beat_r  [NUM_CH];
    logic [CNT_WIDTH-1:0] byte_r  [NUM_CH];
    logic [CNT_WIDTH-1:0] pkt_r   [NUM_CH];
    logic [CNT_WIDTH-1:0] stall_r [NUM_CH];

    logic [CNT_WIDTH-1:0] beat_n  [NUM_CH];
    logic [CNT_WIDTH-1:0] byte_n  [NUM_CH];
    logic [CNT_WIDTH-1:0] pkt_n   [NUM_CH];
    logic [CNT_WIDTH-1:0] stall_n [NUM_CH];
    logic [NUM_CH-1:0]    hs;
    logic [NUM_CH-1:0]    stl;
    logic [NUM_CH-1:0]    full_hit;
    logic [PC_W-1:0]      pc [NUM_CH];
    logic [CNT_WIDTH-1:0] cyc_n;
    logic                 any_hs;
    logic                 win_hit;
    logic                 unb_sat;
    logic                 count_en;
    logic                 fin;

    function automatic logic [PC_W-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            s = s + PC_W'(k[i]);
        end
        return s;
    endfunction

    // Carry out of the widened sum means the counter would wrap, so clamp to all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PC_W-1:0]      b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(CNT_WIDTH + 1 - PC_W){1'b0}}, b};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        hs       = mon_tvalid & mon_tready;
        stl      = mon_tvalid & ~mon_tready;
        any_hs   = |hs;
        cyc_n    = sat_add(cycle_r, PC_W'(1));
        full_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pc[c]      = popcnt(mon_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]);
            beat_n[c]  = sat_add(beat_r[c], PC_W'(hs[c]));
            byte_n[c]  = sat_add(byte_r[c], hs[c] ? pc[c] : '0);
            pkt_n[c]   = sat_add(pkt_r[c], PC_W'(hs[c] & mon_tlast[c]));
            stall_n[c] = sat_add(stall_r[c], PC_W'(stl[c]));
            full_hit[c] = (&beat_n[c]) | (&byte_n[c]) | (&pkt_n[c]) | (&stall_n[c]);
        end
        win_hit  = (win_r != '0) && (cyc_n == win_r);
        unb_sat  = (win_r == '0) && (&cyc_n);
        fin      = win_hit | unb_sat;
        // The arming handshake cycle is itself the first measured cycle; stop always wins.
        count_en = !stop && ((state == MEASURE) || ((state == ARMED) && any_hs));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            win_r    <= '0;
            cycle_r  <= '0;
            cnt_full <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                beat_r[c]  <= '0;
                byte_r[c]  <= '0;
                pkt_r[c]   <= '0;
                stall_r[c] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !stop) begin
                        state    <= start_on_first ? ARMED : MEASURE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        win_r    <= window_cycles;
                        cycle_r  <= '0;
                        cnt_full <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            beat_r[c]  <= '0;
                            byte_r[c]  <= '0;
                            pkt_r[c]   <= '0;
                            stall_r[c] <= '0;
                        end
                    end
                end
                ARMED, MEASURE: begin
                    if (stop || (count_en && fin)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (count_en) begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            if (count_en) begin
                cycle_r  <= cyc_n;
                // Saturating the cycle counter in unbounded mode invalidates every channel's snapshot.
                cnt_full <= cnt_full | full_hit | {NUM_CH{unb_sat}};
                for (int c = 0; c < NUM_CH; c++) begin
                    beat_r[c]  <= beat_n[c];
                    byte_r[c]  <= byte_n[c];
                    pkt_r[c]   <= pkt_n[c];
                    stall_r[c] <= stall_n[c];
                end
            end
        end
    end

    assign cycle_count = cycle_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign beat_count [c*CNT_WIDTH +: CNT_WIDTH] = beat_r[c];
        assign byte_count [c*CNT_WIDTH +: CNT_WIDTH] = byte_r[c];
        assign pkt_count  [c*CNT_WIDTH +: CNT_WIDTH] = pkt_r[c];
        assign stall_count[c*CNT_WIDTH +: CNT_WIDTH] = stall_r[c];
    end

endmodule

// File: tb/tb_axis_perf_mon_mc.sv
// Bench for axis_perf_mon_mc: a 32-bit-counter instance and an 8-bit-counter instance share one set of stimulus.
module tb_axis_perf_mon_mc;

    localparam int MAXC = 600;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mon_tvalid, mon_tready, mon_tlast;
    logic [127:0] mon_tkeep;
    logic         start, stop, start_on_first;
    logic [31:0]  window_cycles;

    logic         b_busy, b_done, s_busy, s_done;
    logic [31:0]  b_cycle;
    logic [63:0]  b_beat, b_byte, b_pkt, b_stall;
    logic [7:0]   s_cycle;
    logic [15:0]  s_beat, s_byte, s_pkt, s_stall;
    logic [1:0]   b_full, s_full;

    int checks = 0;
    int errors = 0;

    bit          rhs  [2][MAXC+1];
    bit          rstl [2][MAXC+1];
    bit          rlst [2][MAXC+1];
    int          rby  [2][MAXC+1];
    logic [63:0] obs_done [MAXC+1];
    logic [63:0] obs_busy [MAXC+1];

    longint      e_cyc;
    longint      e_cnt [4][2];
    logic [63:0] e_full;
    int          done_from;

    always #5 clk = ~clk;

    axis_perf_mon_mc #(.NUM_CH(2), .KEEP_WIDTH(64), .CNT_WIDTH(32)) u_big (
        .CLK(clk), .RST_N(rst_n),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep),
        .start(start), .stop(stop), .start_on_first(start_on_first), .window_cycles(window_cycles),
        .busy(b_busy), .done(b_done), .cycle_count(b_cycle),
        .beat_count(b_beat), .byte_count(b_byte), .pkt_count(b_pkt), .stall_count(b_stall),
        .cnt_full(b_full)
    );

    axis_perf_mon_mc #(.NUM_CH(2), .KEEP_WIDTH(64), .CNT_WIDTH(8)) u_small (
        .CLK(clk), .RST_N(rst_n),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep),
        .start(start), .stop(stop), .start_on_first(start_on_first), .window_cycles(window_cycles[7:0]),
        .busy(s_busy), .done(s_done), .cycle_count(s_cycle),
        .beat_count(s_beat), .byte_count(s_byte), .pkt_count(s_pkt), .stall_count(s_stall),
        .cnt_full(s_full)
    );

    // what: 0 cycle, 1 beat, 2 byte, 3 pkt, 4 stall, 5 cnt_full, 6 busy, 7 done
    function automatic logic [63:0] rd(input int sel, input int what, input int ch);
        logic [63:0] v;
        v = '0;
        if (sel == 0) begin
            case (what)
                0: v = 64'(b_cycle);
                1: v = 64'(b_beat [ch*32 +: 32]);
                2: v = 64'(b_byte [ch*32 +: 32]);
                3: v = 64'(b_pkt  [ch*32 +: 32]);
                4: v = 64'(b_stall[ch*32 +: 32]);
                5: v = 64'(b_full);
                6: v = 64'(b_busy);
                7: v = 64'(b_done);
                default: v = '0;
            endcase
        end else begin
            case (what)
                0: v = 64'(s_cycle);
                1: v = 64'(s_beat [ch*8 +: 8]);
                2: v = 64'(s_byte [ch*8 +: 8]);
                3: v = 64'(s_pkt  [ch*8 +: 8]);
                4: v = 64'(s_stall[ch*8 +: 8]);
                5: v = 64'(s_full);
                6: v = 64'(s_busy);
                7: v = 64'(s_done);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mon_tvalid = '0;
        mon_tready = '0;
        mon_tlast  = '0;
        mon_tkeep  = '0;
    endtask

    task automatic rand_ch(input int ch);
        mon_tvalid[ch]          = ($urandom_range(3) != 0);
        mon_tready[ch]          = ($urandom_range(1) == 1);
        mon_tlast[ch]           = ($urandom_range(3) == 0);
        mon_tkeep[ch*64 +: 64]  = {$urandom, $urandom};
    endtask

    // 0 random, 1 ch0 full-rate full-keep, 2 ch0 ready toggling, 3 arm on ch1 at k=37, 4 silent
    task automatic set_stim(input int mode, input int k);
        idle();
        case (mode)
            0: begin rand_ch(0); rand_ch(1); end
            1: begin
                mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1;
                mon_tkeep[63:0] = '1; mon_tlast[0] = (k % 4 == 0);
            end
            2: begin
                mon_tvalid[0] = 1'b1; mon_tready[0] = (k % 2 == 1);
                mon_tkeep[63:0] = 64'h0000_0000_FFFF_FFFF; mon_tlast[0] = ($urandom_range(1) == 1);
            end
            3: begin
                if (k < 37) begin
                    mon_tvalid[0] = 1'b1;
                end else if (k == 37) begin
                    mon_tvalid[1] = 1'b1; mon_tready[1] = 1'b1; mon_tlast[1] = 1'b1;
                    mon_tkeep[127:64] = {$urandom, $urandom};
                end else begin
                    rand_ch(0); rand_ch(1);
                end
            end
            default: ;
        endcase
    endtask

    function automatic longint sat(input longint x, input longint m);
        return (x > m) ? m : x;
    endfunction

    // Replays the recorded stimulus against the measurement rules; counts are clamped at the end.
    task automatic model(input int win, input bit sof, input int stop_at, input int ncyc, input longint maxv);
        int     ms;
        longint cyc;
        longint s [4][2];
        bit     forced;
        ms = sof ? 0 : 1;
        done_from = 0;
        cyc = 0;
        forced = 0;
        for (int w = 0; w < 4; w++) for (int c = 0; c < 2; c++) s[w][c] = 0;
        if (sof) begin
            for (int k = 1; k <= ncyc; k++) begin
                if (k == stop_at) begin done_from = k + 1; break; end
                if (rhs[0][k] || rhs[1][k]) begin ms = k; break; end
            end
        end
        if (ms != 0) begin
            for (int k = ms; k <= ncyc; k++) begin
                if (k == stop_at) begin done_from = k + 1; break; end
                cyc++;
                for (int c = 0; c < 2; c++) begin
                    s[0][c] += longint'(rhs[c][k]);
                    s[1][c] += longint'(rby[c][k]);
                    s[2][c] += longint'(rhs[c][k] && rlst[c][k]);
                    s[3][c] += longint'(rstl[c][k]);
                end
                if (win != 0 && cyc == longint'(win)) begin done_from = k + 1; break; end
                if (win == 0 && cyc >= maxv) begin done_from = k + 1; forced = 1; break; end
            end
        end
        e_cyc = sat(cyc, maxv);
        e_full = '0;
        for (int c = 0; c < 2; c++) begin
            for (int w = 0; w < 4; w++) begin
                e_cnt[w][c] = sat(s[w][c], maxv);
                if (s[w][c] >= maxv) e_full[c] = 1'b1;
            end
            if (forced) e_full[c] = 1'b1;
        end
    endtask

    task automatic chk_final(input int sel, input string tag);
        chk({tag, "_cycle"}, rd(sel, 0, 0), 64'(e_cyc));
        for (int c = 0; c < 2; c++)
            for (int w = 1; w <= 4; w++)
                chk($sformatf("%s_cnt%0d_ch%0d", tag, w, c), rd(sel, w, c), 64'(e_cnt[w-1][c]));
        chk({tag, "_cnt_full"}, rd(sel, 5, 0), e_full);
    endtask

    task automatic run(input int mode, input int win, input bit sof, input int stop_at,
                       input int ncyc, input int sel, input string tag);
        longint maxv;
        maxv = (sel == 0) ? 64'hFFFF_FFFF : 64'hFF;
        @(negedge clk);
        idle();
        start = 1'b1; stop = 1'b0; start_on_first = sof; window_cycles = win;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (k == stop_at);
            obs_done[k] = rd(sel, 7, 0);
            obs_busy[k] = rd(sel, 6, 0);
            if (k == 1) begin
                chk({tag, "_busy_first"}, obs_busy[k], 64'd1);
                chk({tag, "_cycle_first"}, rd(sel, 0, 0), 64'd0);
            end
            set_stim(mode, k);
            for (int c = 0; c < 2; c++) begin
                rhs[c][k]  = mon_tvalid[c] && mon_tready[c];
                rstl[c][k] = mon_tvalid[c] && !mon_tready[c];
                rlst[c][k] = mon_tlast[c];
                rby[c][k]  = rhs[c][k] ? $countones(mon_tkeep[c*64 +: 64]) : 0;
            end
        end
        @(negedge clk);
        idle();
        stop = 1'b0;
        model(win, sof, stop_at, ncyc, maxv);
        if (done_from >= 2 && done_from <= ncyc) begin
            chk({tag, "_done_before"}, obs_done[done_from-1], 64'd0);
            chk({tag, "_done_edge"},   obs_done[done_from],   64'd1);
            chk({tag, "_busy_edge"},   obs_busy[done_from],   64'd0);
        end
        chk({tag, "_done_end"}, rd(sel, 7, 0), 64'd1);
        chk_final(sel, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; start_on_first = 1'b0; window_cycles = '0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_busy", rd(0, 6, 0), 64'd0);
        chk("rst_done", rd(0, 7, 0), 64'd0);
        chk("rst_cycle", rd(0, 0, 0), 64'd0);
        chk("rst_beat1", rd(0, 1, 1), 64'd0);
        chk("rst_full", rd(0, 5, 0), 64'd0);
        rst_n = 1'b1;

        // start together with stop in IDLE is ignored
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("idle_ss_busy", rd(0, 6, 0), 64'd0);
        chk("idle_ss_done", rd(0, 7, 0), 64'd0);

        run(1, 100, 0, 0, 110, 0, "win100");
        chk("win100_cycle_k", rd(0, 0, 0), 64'd100);
        chk("win100_beat0_k", rd(0, 1, 0), 64'd100);
        chk("win100_byte0_k", rd(0, 2, 0), 64'd6400);
        chk("win100_pkt0_k",  rd(0, 3, 0), 64'd25);
        chk("win100_done_k",  64'(done_from), 64'd101);

        run(3, 10, 1, 0, 60, 0, "arm37");
        chk("arm37_busy_armed", obs_busy[36], 64'd1);
        chk("arm37_done_k", 64'(done_from), 64'd47);

        run(2, 20, 0, 0, 30, 0, "toggle");
        chk("toggle_beat0_k",  rd(0, 1, 0), 64'd10);
        chk("toggle_stall0_k", rd(0, 4, 0), 64'd10);
        chk("toggle_byte0_k",  rd(0, 2, 0), 64'd320);

        run(0, 50, 0, 0, 60, 0, "rand50");

        run(0, 0, 0, 501, 505, 0, "stopw0");
        chk("stopw0_cycle_k", rd(0, 0, 0), 64'd500);

        // start+stop together in DONE keeps the snapshot
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("simul_done", rd(0, 7, 0), 64'd1);
        chk("simul_busy", rd(0, 6, 0), 64'd0);
        chk_final(0, "simul");

        run(0, 30, 1, 0, 40, 0, "randsof");
        run(4, 0, 1, 5, 10, 0, "armstop");

        // reset during MEASURE
        @(negedge clk); idle(); start = 1'b1; start_on_first = 1'b0; window_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); start = 1'b0; set_stim(0, k);
        end
        @(negedge clk); idle(); rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy",  rd(0, 6, 0), 64'd0);
        chk("mrst_done",  rd(0, 7, 0), 64'd0);
        chk("mrst_cycle", rd(0, 0, 0), 64'd0);
        chk("mrst_beat0", rd(0, 1, 0), 64'd0);
        chk("mrst_byte1", rd(0, 2, 1), 64'd0);
        chk("mrst_full",  rd(0, 5, 0), 64'd0);
        rst_n = 1'b1;
        run(0, 40, 0, 0, 50, 0, "postrst");

        // saturation on the 8-bit instance, unbounded window
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run(1, 0, 0, 0, 270, 1, "sat8");
        chk("sat8_byte0_k",  rd(1, 2, 0), 64'd255);
        chk("sat8_cycle_k",  rd(1, 0, 0), 64'd255);
        chk("sat8_full_k",   rd(1, 5, 0), 64'd3);
        chk("sat8_done_k",   64'(done_from), 64'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
